// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin front end for the single-ported DMEM: byte-lane store
// steering, sub-word load extraction/extension and a one-cycle response stage.
module dmem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [1:0]                          req_valid_in,
    output logic [1:0]                          req_ready_out,
    input  logic [1:0]                          req_we_in,
    input  logic [1:0][2:0]                     req_func_in,
    input  logic [1:0][ADDR_WIDTH+1:0]          req_addr_in,
    input  logic [1:0][DATA_WIDTH-1:0]          req_wdata_in,
    output logic [1:0]                          resp_valid_out,
    output logic [DATA_WIDTH-1:0]               resp_rdata_out,
    output logic                                resp_err_out,
    output logic                                mem_en_out,
    output logic [3:0]                          mem_we_out,
    output logic [ADDR_WIDTH-1:0]               mem_addr_out,
    output logic [DATA_WIDTH-1:0]               mem_din_out,
    input  logic [DATA_WIDTH-1:0]               mem_dout_in
);

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct packed {
        logic       id;
        logic       we;
        logic [2:0] func;
        logic [1:0] off;
        logic       err;
    } resp_ctx_t;

    logic                  last_grant_q, last_grant_d;
    logic                  act_q, act_d;
    resp_ctx_t             ctx_q, ctx_d;

    logic                  gnt_id;
    logic                  accept;
    logic                  sel_we;
    logic [2:0]            sel_func;
    logic [ADDR_WIDTH+1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0]            off;
    logic                  illegal, misal, issue;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ld_data;

    // Ties go to the port that did not win last; a lone requester always wins.
    always_comb begin
        gnt_id = (req_valid_in == 2'b11) ? ~last_grant_q : req_valid_in[1];
        accept = rst && (|req_valid_in);
        req_ready_out = 2'b00;
        if (accept) req_ready_out[gnt_id] = 1'b1;
    end

    assign sel_we    = req_we_in[gnt_id];
    assign sel_func  = req_func_in[gnt_id];
    assign sel_addr  = req_addr_in[gnt_id];
    assign sel_wdata = req_wdata_in[gnt_id];
    assign off       = sel_addr[1:0];

    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        unique case (sel_func)
            F_B:        illegal = 1'b0;
            F_H:        misal   = off[0];
            F_W:        misal   = (off != 2'b00);
            F_BU:       illegal = sel_we;
            F_HU: begin
                illegal = sel_we;
                misal   = off[0];
            end
            default:    illegal = 1'b1;
        endcase
    end

    assign issue = accept && !(illegal || misal);

    always_comb begin
        be = 4'b0000;
        unique case (sel_func[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
    end

    assign mem_en_out   = issue;
    assign mem_we_out   = (issue && sel_we) ? be : 4'b0000;
    assign mem_addr_out = sel_addr[ADDR_WIDTH+1:2];
    assign mem_din_out  = sel_wdata << {off, 3'b000};

    always_comb begin
        last_grant_d = accept ? gnt_id : last_grant_q;
        act_d        = accept;
        ctx_d        = ctx_q;
        if (accept) begin
            ctx_d.id   = gnt_id;
            ctx_d.we   = sel_we;
            ctx_d.func = sel_func;
            ctx_d.off  = off;
            ctx_d.err  = illegal || misal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            act_q        <= 1'b0;
            ctx_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            act_q        <= act_d;
            ctx_q        <= ctx_d;
        end
    end

    assign shifted = mem_dout_in >> {ctx_q.off, 3'b000};

    always_comb begin
        ld_data = shifted;
        unique case (ctx_q.func)
            F_B:     ld_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F_BU:    ld_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            F_H:     ld_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F_HU:    ld_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    // Reset also squashes a response already sitting in the pipeline register.
    always_comb begin
        resp_valid_out = 2'b00;
        if (act_q && rst) resp_valid_out[ctx_q.id] = 1'b1;
        resp_err_out   = act_q && rst && ctx_q.err;
        resp_rdata_out = (act_q && rst && !ctx_q.we && !ctx_q.err) ? ld_data : '0;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-ported data memory between two requesters: port 0 is the core load/store unit and port 1 is the IO/DMA master. Each cycle it grants at most one request using round-robin arbitration. It turns byte-addressed sub-word stores into shifted write data plus per-byte write enables, and turns sub-word loads into aligned, sign- or zero-extended results. It sits between the memory stage and the DMEM block RAM, which has a fixed one-cycle read latency.

## Interface
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 14, DMEM word-address width; byte addresses are ADDR_WIDTH+2 bits.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid_in  in  2  per-port request valid; bit i belongs to port i.
- req_ready_out  out  2  per-port grant; the request is accepted in a cycle where valid and ready are both 1.
- req_we_in  in  2  per-port store (1) or load (0).
- req_func_in  in  2x3  per-port funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr_in  in  2x(ADDR_WIDTH+2)  per-port byte address.
- req_wdata_in  in  2xDATA_WIDTH  per-port store data, right-aligned.
- resp_valid_out  out  2  per-port one-cycle response pulse.
- resp_rdata_out  out  DATA_WIDTH  load result; shared by both ports, qualified by resp_valid_out.
- resp_err_out  out  1  misaligned or illegal request; qualified by resp_valid_out.
- mem_en_out  out  1  DMEM enable.
- mem_we_out  out  4  DMEM byte write enables.
- mem_addr_out  out  ADDR_WIDTH  DMEM word address, equal to byte address [ADDR_WIDTH+1:2].
- mem_din_out  out  DATA_WIDTH  DMEM write data.
- mem_dout_in  in  DATA_WIDTH  DMEM read data, valid the cycle after a read enable.

## Operation
- **Arbitration:**
  - Combinational from req_valid_in and the last_grant register.
  - If exactly one port is valid, that port is granted.
  - If both are valid, the port opposite last_grant is granted.
  - last_grant updates to the granted port on every accept.
  - At most one bit of req_ready_out is high; ready is 0 for a port whose valid is 0.
- **Legality check** on the granted request, with off = addr[1:0]:
  - Illegal func: 011, 110, 111, and 100/101 with we=1.
  - Misaligned: H/HU with off odd; W with off≠0.
  - An illegal or misaligned request is still accepted but not issued: mem_en_out=0, mem_we_out=0. It still gets a response with err=1.
- **Store issue:**
  - mem_din_out = wdata << (8*off).
  - mem_we_out: W → 1111; H → 0011<<off; B → 0001<<off.
  - mem_en_out=1.
- **Load issue:** mem_en_out=1, mem_we_out=0000.
- **No grant:** mem_en_out=0, mem_we_out=0; mem_addr_out and mem_din_out are don't-care.
- **Response pipeline register** captures port id, we, func, off, err, and an active flag on every accept.
  - Next cycle: resp_valid_out[id]=1 and resp_err_out=err.
  - resp_rdata_out = 0 for stores and errors.
  - For loads, s = mem_dout_in >> (8*off):
    - B: sign-extend s[7:0].
    - BU: zero-extend s[7:0].
    - H: sign-extend s[15:0].
    - HU: zero-extend s[15:0].
    - W: s.
- **No response backpressure:** requesters must consume a response in its valid cycle.
- **Throughput:** one accepted request per cycle, sustained, across any port mix.

## Timing
- **Reset values:**
  - resp_valid_out=00, resp_err_out=0, resp_rdata_out=0.
  - The pipeline active flag is cleared.
  - last_grant=1, so port 0 wins the first conflict.
  - mem_en_out=0 and mem_we_out=0 while rst=0.
  - req_ready_out=00 while rst=0.
- **Accept at cycle T:** DMEM access is in cycle T (combinational); the response is in T+1. Latency is exactly 1 for loads, stores and errors.
- **Back-to-back:** a response at T+1 and a new accept at T+1 coexist; the response uses the pipeline register, and the issue uses current inputs.
- **Reset asserted in cycle T+1 after an accept at T:** no response is generated and the request is dropped. A store issued at T has already been written.
- **Same-address store then load on consecutive cycles:** the load sees the stored data (DMEM is write-first on a different cycle); no forwarding is required.

## Test plan
- **Store sub-word:** port 0 SB addr 0x0003 data 0x000000AB → mem_we_out=1000, mem_din_out=0xAB000000, mem_addr_out=0. Next cycle resp_valid_out=01, err=0.
- **Load sign/zero extension:** memory word 0x80F0_7F01 at word 4.
  - LB addr 0x12 → 0xFFFFFFF0.
  - LBU addr 0x12 → 0x000000F0.
  - LH addr 0x12 → 0xFFFF80F0.
  - LHU addr 0x10 → 0x00007F01.
- **Round-robin:** both ports continuously valid from reset → grants 0,1,0,1. Port 1 alone valid → granted every cycle. Then both valid → port 0 granted.
- **Misaligned/illegal:**
  - SH addr 0x1 → mem_en_out=0, then resp_err_out=1 with rdata 0.
  - LW addr 0x2 → same result.
  - func 110 → same result.
- **Back-to-back pipeline:** SW 0xDEADBEEF to 0x20, LW 0x20 next cycle, LB 0x21 → rdata 0xDEADBEEF then 0xFFFFFFBE, one response per cycle.
- **Reset mid-operation:** accept LW at T, assert rst at T+1 → resp_valid_out stays 00. After release, the first conflict is granted to port 0.
